// File: rtl/mant_mul_seq_pkg.sv
// Shared SPFP mantissa constants and the multiplier controller state encoding.
package mant_mul_seq_pkg;

    localparam int MANT_W = 24;
    localparam int PROD_W = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mant_mul_seq_rca24bit.sv
// Ripple-carry adder shared across the shift-and-add iterations.
module rca24bit #(
    parameter int width = 24
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             c_out
);

    always_comb begin : ripple
        logic c;
        sum = '0;
        c   = cin;
        for (int unsigned i = 0; i < width; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        c_out = c;
    end

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential shift-and-add mantissa multiplier: one adder reused for WIDTH cycles
// to produce the exact 2*WIDTH-bit product, with valid/ready on both sides.
module mant_mul_seq
    import mant_mul_seq_pkg::*;
#(
    parameter  int WIDTH = MANT_W,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   p;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 c_out;
    logic                 zero_op;
    logic                 last;

    assign zero_op = (a == '0) || (b == '0);
    assign last    = (cnt == CNT_W'(WIDTH - 1));
    assign addend  = p[0] ? mcand : '0;

    rca24bit #(.width(WIDTH)) u_rca (
        .a     (p[2*WIDTH-1:WIDTH]),
        .b     (addend),
        .cin   (1'b0),
        .sum   (sum),
        .c_out (c_out)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        product   = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = zero_op ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                product   = p;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            p     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (zero_op) begin
                            p <= '0;
                        end else begin
                            mcand <= a;
                            p     <= {{WIDTH{1'b0}}, b};
                            cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    // Carry-out lands in the product MSB, so nothing is ever lost.
                    p   <= {c_out, sum, p[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mant_mul_seq.sv
// Scoreboard bench for mant_mul_seq: driver pushes a*b expectations, monitor checks outputs.
module tb_mant_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [47:0] product;
    logic        busy;

    typedef struct {
        logic [47:0] prod;
        int          acc;
        int          lat;
    } entry_t;

    entry_t sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     ready_mode = 0;

    mant_mul_seq #(.WIDTH(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: first cycle of each out_valid pops the scoreboard; later stalled cycles must hold.
    bit          holding = 0;
    bit          prev_xfer = 0;
    logic [47:0] held;
    always @(negedge clk) begin
        entry_t e;
        if (rst) begin
            holding   = 0;
            prev_xfer = 0;
        end else begin
            if (prev_xfer) begin
                chk("out_valid_after_xfer", 48'(out_valid), 48'd0);
                chk("in_ready_after_xfer", 48'(in_ready), 48'd1);
            end
            if (out_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h expected none", product);
                    end else begin
                        e = sb.pop_front();
                        chk("product", product, e.prod);
                        chk("latency", 48'(cyc - e.acc), 48'(e.lat));
                    end
                    holding = 1;
                    held    = product;
                end else begin
                    chk("product_hold", product, held);
                end
                chk("in_ready_in_done", 48'(in_ready), 48'd0);
                if (out_ready) holding = 0;
            end
            prev_xfer = out_valid && out_ready;
        end
    end

    task automatic issue(input logic [23:0] x, input logic [23:0] y, input bit track);
        int     waited = 0;
        entry_t e;
        in_valid = 1'b1;
        a = x;
        b = y;
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 within 1000 cycles");
            in_valid = 1'b0;
            return;
        end
        e.prod = 48'(x) * 48'(y);
        e.acc  = cyc;
        e.lat  = (x == 0 || y == 0) ? 1 : 25;
        @(posedge clk);
        if (track) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (!(sb.size() == 0 && in_ready && !out_valid) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 48'(in_ready), 48'd1);
        chk("rst_out_valid", 48'(out_valid), 48'd0);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_product", product, 48'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases: small, all-ones carry path, MSB only, zero shortcuts.
        issue(24'd3, 24'd5, 1);               drain();
        issue(24'hFFFFFF, 24'hFFFFFF, 1);     drain();
        issue(24'h800000, 24'h800000, 1);     drain();
        issue(24'h000000, 24'hABCDEF, 1);     drain();
        issue(24'h123456, 24'h000000, 1);     drain();

        // Stalled output with ignored in_valid pulses.
        ready_mode = 2;
        @(negedge clk);
        issue(24'h123456, 24'h654321, 1);
        begin
            int w = 0;
            while (!out_valid && w < 100) begin
                @(negedge clk);
                w++;
            end
            chk("stall_out_valid", 48'(out_valid), 48'd1);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 24'($urandom);
            b = 24'($urandom);
            chk("stall_in_ready", 48'(in_ready), 48'd0);
            chk("stall_busy", 48'(busy), 48'd1);
            @(negedge clk);
        end
        in_valid   = 1'b0;
        ready_mode = 0;
        drain();

        // Reset in the middle of RUN discards the operation.
        issue(24'h123456, 24'h654321, 0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 48'(in_ready), 48'd1);
        chk("midrst_out_valid", 48'(out_valid), 48'd0);
        chk("midrst_product", product, 48'd0);
        chk("midrst_busy", 48'(busy), 48'd0);
        rst = 1'b0;
        @(negedge clk);
        issue(24'd7, 24'd9, 1);
        drain();

        // Randomised back-to-back traffic with random downstream stalls.
        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            logic [23:0] x, y;
            x = 24'($urandom);
            y = 24'($urandom);
            if ($urandom_range(0, 15) == 0) x = '0;
            if ($urandom_range(0, 15) == 0) y = '0;
            issue(x, y, 1);
        end
        drain();
        ready_mode = 0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
